// File: rtl/jump_controller_pkg.sv
// Shared constants for the branch/jump redirect logic.
package jump_controller_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned FUNC3_W = 3;

    // Branch-type encodings carried in the instruction's funct3 field
    localparam logic [FUNC3_W-1:0] F3_BEQ  = 3'b000;
    localparam logic [FUNC3_W-1:0] F3_BNE  = 3'b001;
    localparam logic [FUNC3_W-1:0] F3_BLT  = 3'b100;
    localparam logic [FUNC3_W-1:0] F3_BGE  = 3'b101;
    localparam logic [FUNC3_W-1:0] F3_BLTU = 3'b110;
    localparam logic [FUNC3_W-1:0] F3_BGEU = 3'b111;

endpackage : jump_controller_pkg

// File: rtl/branch_condition_eval.sv
// Combinational branch condition from funct3 and the ALU compare flags.
module branch_condition_eval
    import jump_controller_pkg::*;
(
    input  logic [FUNC3_W-1:0] func3,
    input  logic               zero,
    input  logic               sign_lt,
    input  logic               unsigned_lt,
    output logic               cond_c
);

    // Decode funct3; reserved encodings (010, 011) never take the branch
    always_comb begin
        cond_c = 1'b0;
        case (func3)
            F3_BEQ:  cond_c = zero;
            F3_BNE:  cond_c = ~zero;
            F3_BLT:  cond_c = sign_lt & ~zero;
            F3_BGE:  cond_c = ~sign_lt | zero;
            F3_BLTU: cond_c = unsigned_lt & ~zero;
            F3_BGEU: cond_c = ~unsigned_lt | zero;
            default: cond_c = 1'b0;
        endcase
    end

endmodule : branch_condition_eval

// File: rtl/jump_controller.sv
// PC redirect controller: selects the jump/branch target and registers
// the redirect and pipeline-flush controls with one cycle of latency.
module jump_controller
    import jump_controller_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic [ADDR_W-1:0]  BRANCH_ADDR,
    input  logic [ADDR_W-1:0]  JUMP_I,
    input  logic [FUNC3_W-1:0] FUNC3,
    input  logic               BRANCH,
    input  logic               JUMP,
    input  logic               ZERO,
    input  logic               SIGN,
    input  logic               UNSIGNED,
    output logic [ADDR_W-1:0]  BRANCH_OR_JUMP_ADDR,
    output logic               PC_MUX_CONTROL,
    output logic               REG_FLUSH
);

    logic              cond_c;
    logic              taken_c;
    logic [ADDR_W-1:0] target_c;

    branch_condition_eval u_cond (
        .func3       (FUNC3),
        .zero        (ZERO),
        .sign_lt     (SIGN),
        .unsigned_lt (UNSIGNED),
        .cond_c      (cond_c)
    );

    // Jump wins over branch; target choice does not depend on taken
    always_comb begin
        taken_c  = JUMP | (BRANCH & cond_c);
        target_c = JUMP ? JUMP_I : BRANCH_ADDR;
    end

    // Output registers; flush always mirrors the PC mux select
    always_ff @(posedge CLK) begin
        if (RESET) begin
            BRANCH_OR_JUMP_ADDR <= '0;
            PC_MUX_CONTROL      <= 1'b0;
            REG_FLUSH           <= 1'b0;
        end else begin
            BRANCH_OR_JUMP_ADDR <= target_c;
            PC_MUX_CONTROL      <= taken_c;
            REG_FLUSH           <= taken_c;
        end
    end

endmodule : jump_controller

// File: tb/tb_jump_controller.sv
// Directed self-checking bench for jump_controller.
module tb_jump_controller;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] BRANCH_ADDR;
    logic [31:0] JUMP_I;
    logic [2:0]  FUNC3;
    logic        BRANCH;
    logic        JUMP;
    logic        ZERO;
    logic        SIGN;
    logic        UNSIGNED;
    logic [31:0] BRANCH_OR_JUMP_ADDR;
    logic        PC_MUX_CONTROL;
    logic        REG_FLUSH;

    int checks   = 0;
    int failures = 0;

    jump_controller dut (
        .CLK                 (CLK),
        .RESET               (RESET),
        .BRANCH_ADDR         (BRANCH_ADDR),
        .JUMP_I              (JUMP_I),
        .FUNC3               (FUNC3),
        .BRANCH              (BRANCH),
        .JUMP                (JUMP),
        .ZERO                (ZERO),
        .SIGN                (SIGN),
        .UNSIGNED            (UNSIGNED),
        .BRANCH_OR_JUMP_ADDR (BRANCH_OR_JUMP_ADDR),
        .PC_MUX_CONTROL      (PC_MUX_CONTROL),
        .REG_FLUSH           (REG_FLUSH)
    );

    always #5 CLK = ~CLK;

    // Single comparison point for the whole bench
    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Apply one vector, clock once, then compare all three outputs
    task automatic step(input string tag, input logic br, input logic jp,
                        input logic [2:0] f3, input logic z, input logic s,
                        input logic u, input logic [31:0] ba,
                        input logic [31:0] ji, input logic [31:0] exp_addr,
                        input logic exp_taken);
        BRANCH      = br;
        JUMP        = jp;
        FUNC3       = f3;
        ZERO        = z;
        SIGN        = s;
        UNSIGNED    = u;
        BRANCH_ADDR = ba;
        JUMP_I      = ji;
        @(posedge CLK);
        #1;
        check({tag, ".addr"},  BRANCH_OR_JUMP_ADDR, exp_addr);
        check({tag, ".pcmux"}, 32'(PC_MUX_CONTROL), 32'(exp_taken));
        check({tag, ".flush"}, 32'(REG_FLUSH),      32'(exp_taken));
    endtask

    localparam logic [31:0] BA = 32'h0000_1000;
    localparam logic [31:0] JI = 32'h0000_2000;

    initial begin
        RESET = 1'b1;
        BRANCH = 1'b0; JUMP = 1'b0; FUNC3 = 3'b000;
        ZERO = 1'b0; SIGN = 1'b0; UNSIGNED = 1'b0;
        BRANCH_ADDR = BA; JUMP_I = JI;
        @(posedge CLK); #1;
        check("reset.addr",  BRANCH_OR_JUMP_ADDR, 32'h0);
        check("reset.pcmux", 32'(PC_MUX_CONTROL), 32'h0);
        check("reset.flush", 32'(REG_FLUSH),      32'h0);
        RESET = 1'b0;

        //    tag          br    jp    f3      z     s     u     ba  ji  addr  taken
        step("jal",       1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, BA, JI, JI,   1'b1);
        step("jump_prio", 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, BA, JI, JI,   1'b1);
        step("beq_t",     1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, BA, JI, BA,   1'b1);
        step("beq_nt",    1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, BA, JI, BA,   1'b0);
        step("bne_t",     1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, BA, JI, BA,   1'b1);
        step("bne_nt",    1'b1, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, BA, JI, BA,   1'b0);
        step("blt_t",     1'b1, 1'b0, 3'b100, 1'b0, 1'b1, 1'b0, BA, JI, BA,   1'b1);
        step("blt_eq",    1'b1, 1'b0, 3'b100, 1'b1, 1'b1, 1'b0, BA, JI, BA,   1'b0);
        step("bge_t",     1'b1, 1'b0, 3'b101, 1'b0, 1'b0, 1'b0, BA, JI, BA,   1'b1);
        step("bge_nt",    1'b1, 1'b0, 3'b101, 1'b0, 1'b1, 1'b0, BA, JI, BA,   1'b0);
        step("bltu_t",    1'b1, 1'b0, 3'b110, 1'b0, 1'b0, 1'b1, BA, JI, BA,   1'b1);
        step("bltu_nt",   1'b1, 1'b0, 3'b110, 1'b0, 1'b1, 1'b0, BA, JI, BA,   1'b0);
        step("bltu_eq",   1'b1, 1'b0, 3'b110, 1'b1, 1'b0, 1'b1, BA, JI, BA,   1'b0);
        step("bgeu_t",    1'b1, 1'b0, 3'b111, 1'b0, 1'b1, 1'b0, BA, JI, BA,   1'b1);
        step("bgeu_nt",   1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 1'b1, BA, JI, BA,   1'b0);
        step("rsv_010",   1'b1, 1'b0, 3'b010, 1'b1, 1'b1, 1'b1, BA, JI, BA,   1'b0);
        step("rsv_011",   1'b1, 1'b0, 3'b011, 1'b0, 1'b0, 1'b0, BA, JI, BA,   1'b0);
        step("no_cf",     1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, BA, JI, BA,   1'b0);
        step("no_cf_bge", 1'b0, 1'b0, 3'b101, 1'b0, 1'b0, 1'b0,
             32'hDEAD_BEE0, 32'h1234_5678, 32'hDEAD_BEE0, 1'b0);
        step("jalr_addr", 1'b0, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0,
             32'h0000_0040, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1);

        // Reset mid-sequence with JUMP held: redirect pending in the
        // registers must be dropped, and reset beats JUMP
        RESET = 1'b1;
        BRANCH = 1'b0; JUMP = 1'b1; BRANCH_ADDR = BA; JUMP_I = JI;
        @(posedge CLK); #1;
        check("rst_jump.addr",  BRANCH_OR_JUMP_ADDR, 32'h0);
        check("rst_jump.pcmux", 32'(PC_MUX_CONTROL), 32'h0);
        check("rst_jump.flush", 32'(REG_FLUSH),      32'h0);
        RESET = 1'b0;
        step("post_rst",  1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, BA, JI, JI,   1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_jump_controller
